clk_div_bank: RTL

Parametrised multi-channel clock-enable/divided-clock generator driven from the board reference clock. Produces NUM_CH independently programmable integer-divided clocks with registered 50 %-nearest duty, one-cycle tick strobes and a bank-wide `locked` indication. Runtime reconfiguration goes through a valid/ready port, with glitch-free switching at channel wrap. Sits beside the PLL and feeds the slow peripheral domains, such as the PWM, encoder sampling and IMU polling, with enables derived from a single clock.

---
 rtl/divbank_pkg.sv | 27 ++
 rtl/divbank_channel.sv | 75 +++++++
 rtl/clk_div_bank.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/divbank_pkg.sv
// divbank_pkg: shared types and helpers for the clk_div_bank divider bank.
//   bank_state_e : bank FSM states (LOCKING, PENDING, LOCKED)
//   MIN_DIV      : smallest legal divide ratio
//   clamp_div()  : forces divide ratios below MIN_DIV up to MIN_DIV
package divbank_pkg;

  typedef enum logic [1:0] {
    LOCKING = 2'd0,
    PENDING = 2'd1,
    LOCKED  = 2'd2
  } bank_state_e;

  localparam int MIN_DIV = 2;

  // Callers zero-extend to this width and truncate the result back.
  localparam int CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp_div(input logic [CLAMP_W-1:0] div);
    logic [CLAMP_W-1:0] res;
    res = div;
    if (div < CLAMP_W'(MIN_DIV)) begin
      res = CLAMP_W'(MIN_DIV);
    end
    return res;
  endfunction

endpackage

// File: rtl/divbank_channel.sv
// divbank_channel: one divider channel of clk_div_bank.
//   refclk      : reference clock
//   rst         : asynchronous active-high reset
//   apply_i     : load new_div_i/new_phase_i; honoured only on the wrap cycle
//   new_div_i   : new divide ratio (already clamped by the caller)
//   new_phase_i : start count after apply (out-of-range values load 0)
//   wrap_o      : counter is on its last count (cnt == div-1)
//   outclk_o    : registered divided clock, high while cnt < (div+1)/2
//   tick_o      : registered one-cycle strobe for the last count of a period
module divbank_channel
  import divbank_pkg::*;
#(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 2
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             apply_i,
  input  logic [DIV_W-1:0] new_div_i,
  input  logic [DIV_W-1:0] new_phase_i,
  output logic             wrap_o,
  output logic             outclk_o,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(clamp_div(CLAMP_W'(DEF_DIV)));

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             outclk_q, outclk_d;
  logic             tick_q, tick_d;
  logic             last_cnt;
  // One extra bit so (div+1) cannot overflow for the largest divide value.
  logic [DIV_W:0]   high_len;

  assign last_cnt = (cnt_q == (div_q - DIV_W'(1)));
  assign high_len = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;

  always_comb begin
    cnt_d    = cnt_q + DIV_W'(1);
    div_d    = div_q;
    outclk_d = ({1'b0, cnt_q} < high_len);
    tick_d   = last_cnt;
    // Changes only take effect at the period boundary so the current
    // period always completes and no runt pulse is produced.
    if (last_cnt) begin
      cnt_d = '0;
      if (apply_i) begin
        div_d = new_div_i;
        if (new_phase_i < new_div_i) begin
          cnt_d = new_phase_i;
        end
      end
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      div_q    <= RST_DIV;
      outclk_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
    end
  end

  assign wrap_o   = last_cnt;
  assign outclk_o = outclk_q;
  assign tick_o   = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH programmable integer clock dividers off one refclk,
// with a single pending reconfiguration slot and a bank-wide lock flag.
//   refclk    : sole clock
//   rst       : asynchronous active-high reset
//   cfg_valid : configuration request
//   cfg_ready : bank can accept a request
//   cfg_ch    : target channel (values >= NUM_CH are accepted and dropped)
//   cfg_div   : new divide ratio (0 and 1 are treated as 2)
//   cfg_phase : start count on apply (only with DIVBANK_PHASE_EN)
//   outclk    : registered divided clocks
//   tick      : one-cycle strobe on the last count of each period
//   locked    : all channels stable for LOCK_CYCLES cycles
//   dbg_state : current bank FSM state (bank_state_e encoding)
// Build option: define DIVBANK_PHASE_EN to add cfg_phase and per-request
// start phase; otherwise every apply restarts the channel at count 0.
//
// Handshake: a request transfers on any cycle where cfg_valid && cfg_ready
// at the rising refclk edge. cfg_ready does not depend on cfg_valid; it is
// low during reset and while an in-range update is waiting to be applied.
module clk_div_bank
  import divbank_pkg::*;
#(
  parameter int  NUM_CH      = 2,
  parameter int  DIV_W       = 8,
  parameter int  DEF_DIV     = 2,
  parameter int  LOCK_CYCLES = 16,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
`ifdef DIVBANK_PHASE_EN
  input  logic [DIV_W-1:0]  cfg_phase,
`endif
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked,
  output logic [1:0]        dbg_state
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  bank_state_e      state_q, state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;

  logic [CH_W-1:0]  pend_ch_q;
  logic [DIV_W-1:0] pend_div_q;
  logic [DIV_W-1:0] pend_phase;

  logic             xfer;
  logic             xfer_in_range;
  logic             apply_any;
  logic [NUM_CH-1:0] ch_wrap;
  logic [NUM_CH-1:0] ch_apply;

  assign cfg_ready     = ~rst & (state_q != PENDING);
  assign xfer          = cfg_valid & cfg_ready;
  // Out-of-range requests complete the handshake but leave no trace.
  assign xfer_in_range = xfer & (32'(cfg_ch) < 32'(NUM_CH));
  assign apply_any     = |ch_apply;

  // Pending slot. Only written while not PENDING, so an accepted update
  // can never be overwritten before its channel applies it.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pend_ch_q  <= '0;
      pend_div_q <= '0;
    end else if (xfer_in_range) begin
      pend_ch_q  <= cfg_ch;
      pend_div_q <= DIV_W'(clamp_div(CLAMP_W'(cfg_div)));
    end
  end

`ifdef DIVBANK_PHASE_EN
  logic [DIV_W-1:0] pend_phase_q;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pend_phase_q <= '0;
    end else if (xfer_in_range) begin
      pend_phase_q <= cfg_phase;
    end
  end

  assign pend_phase = pend_phase_q;
`else
  assign pend_phase = '0;
`endif

  // Bank FSM and lock counter.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      LOCKING: begin
        // A new request beats the terminal count: locked never pulses.
        if (xfer_in_range) begin
          state_d    = PENDING;
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_d = LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end
      end
      LOCKED: begin
        if (xfer_in_range) begin
          state_d    = PENDING;
          lock_cnt_d = '0;
        end
      end
      PENDING: begin
        if (apply_any) begin
          state_d    = LOCKING;
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d    = LOCKING;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= LOCKING;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign dbg_state = state_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    // The target channel applies on its own wrap cycle only.
    assign ch_apply[i] = (state_q == PENDING) && (pend_ch_q == CH_W'(i)) && ch_wrap[i];

    divbank_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .refclk      (refclk),
      .rst         (rst),
      .apply_i     (ch_apply[i]),
      .new_div_i   (pend_div_q),
      .new_phase_i (pend_phase),
      .wrap_o      (ch_wrap[i]),
      .outclk_o    (outclk[i]),
      .tick_o      (tick[i])
    );
  end

endmodule
